number_readout_scheduler: RTL

Shares one serial binary-to-BCD converter among up to NUM_REQ on-screen numeric readouts (length, angle, time fields). It arbitrates conversion requests round-robin and holds the per-requester results in a pending bank. At each frame boundary it publishes that bank as tear-free digit and blank signals for the number sprite renderers. It replaces one pipelined converter per readout.

---
 rtl/number_readout_scheduler_pkg.sv | 22 ++
 rtl/number_readout_scheduler_if.sv | 15 +
 rtl/number_readout_scheduler_bcd_serial_converter.sv | 70 +++++++
 rtl/number_readout_scheduler.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/number_readout_scheduler_pkg.sv
// Shared definitions for the number readout scheduler slice.
//   DIGIT_W       : width of one BCD digit
//   sched_state_t : scheduler FSM states
//   pow10()       : 10**n, used for the BCD saturation threshold
package sprite_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    STORE
  } sched_state_t;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/number_readout_scheduler_if.sv
// Request handshake bundle between the readouts and the scheduler.
//   req_valid_in  : per-requester conversion request
//   req_bin_in    : per-requester binary value, slice [r*BIN_WIDTH +: BIN_WIDTH]
//   req_ready_out : one-hot grant from the scheduler
interface number_readout_scheduler_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIN_WIDTH = 12
);
  logic [NUM_REQ-1:0]           req_valid_in;
  logic [NUM_REQ*BIN_WIDTH-1:0] req_bin_in;
  logic [NUM_REQ-1:0]           req_ready_out;

  modport master (output req_valid_in, output req_bin_in, input req_ready_out);
  modport slave  (input req_valid_in, input req_bin_in, output req_ready_out);
endinterface

// File: rtl/number_readout_scheduler_bcd_serial_converter.sv
// Serial double-dabble binary-to-BCD converter, one bit per cycle.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   start_i       : load bin_i and begin BIN_WIDTH shift steps
//   bin_i         : binary value to convert
//   done_o        : high during the cycle whose edge applies the last step
//   bcd_o         : DIGITS BCD nibbles, valid after the last step
module bcd_serial_converter
  import sprite_pkg::*;
#(
  parameter int unsigned BIN_WIDTH = 12,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  input  logic [BIN_WIDTH-1:0]        bin_i,
  output logic                        done_o,
  output logic [DIGITS*DIGIT_W-1:0]   bcd_o
);
  localparam int unsigned BCD_W = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);

  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 active_q, active_d;

  always_comb begin
    adj      = bcd_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_o   = active_q && (cnt_q == CNT_W'(BIN_WIDTH - 1));
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd_q[k*DIGIT_W +: DIGIT_W] >= DIGIT_W'(5))
        adj[k*DIGIT_W +: DIGIT_W] = bcd_q[k*DIGIT_W +: DIGIT_W] + DIGIT_W'(3);
    end
    if (start_i) begin
      bin_d    = bin_i;
      bcd_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      // Digits above DIGITS are dropped; the lower digits stay exact and the
      // scheduler saturates anything that would have needed them.
      bcd_d = BCD_W'({adj, bin_q[BIN_WIDTH-1]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
      if (done_o) active_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/number_readout_scheduler.sv
// Shares one serial BCD converter among NUM_REQ numeric readouts.
// Round-robin arbitration, pending result bank, frame-synchronous display bank.
//   pixel_clk_in, rst_in : clock, asynchronous active-low reset
//   req_if               : request handshake (valid/bin in, one-hot ready out)
//   new_frame_in         : frame-start pulse; display bank loads pending bank
//   digits_out           : frame-stable BCD, requester r digit d at [(r*DIGITS+d)*4 +: 4]
//   blank_out            : leading-zero blank mask, same indexing
//   sat_out              : frame-stable saturation flag per requester
//   busy_out             : conversion in flight
// DIGITS must be at least 2.
module number_readout_scheduler
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned BIN_WIDTH = 12,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                              pixel_clk_in,
  input  logic                              rst_in,
  number_readout_scheduler_if.slave         req_if,
  input  logic                              new_frame_in,
  output logic [NUM_REQ*DIGITS*DIGIT_W-1:0] digits_out,
  output logic [NUM_REQ*DIGITS-1:0]         blank_out,
  output logic [NUM_REQ-1:0]                sat_out,
  output logic                              busy_out
);
  localparam int unsigned     IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned     SLOT_W    = DIGITS * DIGIT_W;
  localparam longint unsigned SAT_LIMIT = pow10(DIGITS);
  localparam logic [NUM_REQ*DIGITS-1:0] BLANK_RST = {NUM_REQ{{(DIGITS-1){1'b1}}, 1'b0}};

  sched_state_t                  state_q, state_d;
  logic [IDX_W-1:0]              ptr_q, ptr_d, idx_q, idx_d;
  logic [BIN_WIDTH-1:0]          cap_q, cap_d;
  logic [NUM_REQ*SLOT_W-1:0]     pend_dig_q, pend_dig_d, disp_dig_q;
  logic [NUM_REQ-1:0]            pend_sat_q, pend_sat_d, disp_sat_q;
  logic [NUM_REQ*DIGITS-1:0]     blank_d, disp_blank_q;

  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx, cand;
  logic [BIN_WIDTH-1:0] grant_bin;
  logic [NUM_REQ-1:0]   ready;
  logic                 conv_start, conv_done, sat_hit, zero_run;
  logic [SLOT_W-1:0]    conv_bcd;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_if.req_valid_in[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    grant_bin = req_if.req_bin_in[grant_idx*BIN_WIDTH +: BIN_WIDTH];
  end

  assign sat_hit = 64'(cap_q) >= SAT_LIMIT;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    cap_d      = cap_q;
    pend_dig_d = pend_dig_q;
    pend_sat_d = pend_sat_q;
    ready      = '0;
    conv_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          ready[grant_idx] = 1'b1;
          conv_start       = 1'b1;
          cap_d            = grant_bin;
          idx_d            = grant_idx;
          ptr_d            = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
          state_d          = SHIFT;
        end
      end
      SHIFT: if (conv_done) state_d = STORE;
      STORE: begin
        pend_dig_d[idx_q*SLOT_W +: SLOT_W] = sat_hit ? {DIGITS{4'd9}} : conv_bcd;
        pend_sat_d[idx_q]                  = sat_hit;
        state_d                            = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Blank mask follows the post-store pending value so a publish in the
  // STORE cycle gets digits and blanks that agree.
  always_comb begin
    blank_d  = '0;
    zero_run = 1'b1;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      zero_run = 1'b1;
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
        zero_run = zero_run & (pend_dig_d[(r*DIGITS + DIGITS-1-k)*DIGIT_W +: DIGIT_W] == '0);
        blank_d[r*DIGITS + DIGITS-1-k] = zero_run;
      end
    end
  end

  bcd_serial_converter #(
    .BIN_WIDTH(BIN_WIDTH),
    .DIGITS   (DIGITS)
  ) u_conv (
    .clk_i  (pixel_clk_in),
    .rst_ni (rst_in),
    .start_i(conv_start),
    .bin_i  (grant_bin),
    .done_o (conv_done),
    .bcd_o  (conv_bcd)
  );

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      cap_q        <= '0;
      pend_dig_q   <= '0;
      pend_sat_q   <= '0;
      disp_dig_q   <= '0;
      disp_sat_q   <= '0;
      disp_blank_q <= BLANK_RST;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      cap_q      <= cap_d;
      pend_dig_q <= pend_dig_d;
      pend_sat_q <= pend_sat_d;
      if (new_frame_in) begin
        disp_dig_q   <= pend_dig_d;
        disp_sat_q   <= pend_sat_d;
        disp_blank_q <= blank_d;
      end
    end
  end

  assign req_if.req_ready_out = ready;
  assign busy_out             = (state_q != IDLE);
  assign digits_out           = disp_dig_q;
  assign blank_out            = disp_blank_q;
  assign sat_out              = disp_sat_q;

endmodule
